// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer: the data width, the opcode map,
//   the FSM state encoding and the immediate-flag bit position.
package fetch_sequencer_pkg;

  localparam int DATA_W  = 8;
  localparam int IMM_BIT = 7;

  localparam logic [DATA_W-1:0] OP_NOP  = 8'h00;
  localparam logic [DATA_W-1:0] OP_HALT = 8'h01;
  localparam logic [DATA_W-1:0] OP_LIA  = 8'h80;
  localparam logic [DATA_W-1:0] OP_LIB  = 8'h81;
  localparam logic [DATA_W-1:0] OP_JMP  = 8'h82;
  localparam logic [DATA_W-1:0] OP_JZ   = 8'h83;
  localparam logic [DATA_W-1:0] OP_JC   = 8'h84;
  localparam logic [DATA_W-1:0] HALT_OP = OP_HALT;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_IMM   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // An opcode with the top bit set is followed by a one-byte immediate.
  function automatic logic has_immediate(input logic [DATA_W-1:0] op);
    return op[IMM_BIT];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the sequencer's bus-side signals.
//   dbus/flagZ/flagC/runEnable : ROM byte, ALU flags and run gate into the sequencer
//   assertRom/doJumpBar        : count and active-low load controls for the pc
//   loadABar/loadBBar          : active-low register-load strobes
//   ir/halted                  : last opcode and halt indication
//   master = sequencer side, slave = surrounding datapath side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
  ();

  logic [DATA_W-1:0] dbus;
  logic              flagZ;
  logic              flagC;
  logic              runEnable;
  logic              assertRom;
  logic              doJumpBar;
  logic              loadABar;
  logic              loadBBar;
  logic [DATA_W-1:0] ir;
  logic              halted;

  modport master (
    input  dbus, flagZ, flagC, runEnable,
    output assertRom, doJumpBar, loadABar, loadBBar, ir, halted
  );

  modport slave (
    output dbus, flagZ, flagC, runEnable,
    input  assertRom, doJumpBar, loadABar, loadBBar, ir, halted
  );

endinterface

// File: rtl/fetch_decode.sv
// fetch_decode
//   Combinational decode of the latched opcode into active-high actions for the
//   immediate cycle.
//   i_ir       : latched opcode
//   i_flag_z   : ALU zero flag
//   i_flag_c   : ALU carry flag
//   o_load_a   : load register A from the immediate
//   o_load_b   : load register B from the immediate
//   o_jump     : load the pc from the immediate
module fetch_decode
  import fetch_sequencer_pkg::*;
  (
  input  logic [DATA_W-1:0] i_ir,
  input  logic              i_flag_z,
  input  logic              i_flag_c,
  output logic              o_load_a,
  output logic              o_load_b,
  output logic              o_jump
);

  // Opcode to action map; unknown immediates simply consume their byte.
  always_comb begin
    o_load_a = 1'b0;
    o_load_b = 1'b0;
    o_jump   = 1'b0;
    case (i_ir)
      OP_LIA:  o_load_a = 1'b1;
      OP_LIB:  o_load_b = 1'b1;
      OP_JMP:  o_jump   = 1'b1;
      OP_JZ:   o_jump   = i_flag_z;
      OP_JC:   o_jump   = i_flag_c;
      default: o_jump   = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch/immediate/halt FSM that drives the program counter and register-load
//   strobes from the ROM byte on dbus.
//   clk      : system clock, rising edge
//   resetBar : asynchronous active-low reset
//   bus      : fetch_sequencer_if master (dbus, flags, runEnable in;
//              assertRom, doJumpBar, loadABar, loadBBar, ir, halted out)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
  (
  input  logic               clk,
  input  logic               resetBar,
  fetch_sequencer_if.master  bus
);

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_ir;
  logic              w_load_a;
  logic              w_load_b;
  logic              w_jump;
  logic              w_assert_rom;
  logic              w_jump_bar;
  logic              w_load_a_bar;
  logic              w_load_b_bar;
  logic              w_halted;

  fetch_decode u_decode (
    .i_ir     (r_ir),
    .i_flag_z (bus.flagZ),
    .i_flag_c (bus.flagC),
    .o_load_a (w_load_a),
    .o_load_b (w_load_b),
    .o_jump   (w_jump)
  );

  // State register.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Opcode register: captures the ROM byte on every enabled fetch cycle.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      r_ir <= 8'h00;
    end else if ((r_state == ST_FETCH) && bus.runEnable) begin
      r_ir <= bus.dbus;
    end else begin
      r_ir <= r_ir;
    end
  end

  // Next-state and strobe generation. Jumps are only ever issued in an enabled
  // IMM cycle, where assertRom is also high, so the pc never sees a load alone.
  always_comb begin
    w_state_next = r_state;
    w_assert_rom = 1'b0;
    w_jump_bar   = 1'b1;
    w_load_a_bar = 1'b1;
    w_load_b_bar = 1'b1;
    w_halted     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (bus.runEnable) begin
          w_assert_rom = 1'b1;
          if (has_immediate(bus.dbus)) begin
            w_state_next = ST_IMM;
          end else if (bus.dbus == HALT_OP) begin
            w_state_next = ST_HALT;
          end else begin
            w_state_next = ST_FETCH;
          end
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_IMM: begin
        if (bus.runEnable) begin
          w_assert_rom = 1'b1;
          w_jump_bar   = ~w_jump;
          w_load_a_bar = ~w_load_a;
          w_load_b_bar = ~w_load_b;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IMM;
        end
      end
      ST_HALT: begin
        w_halted     = 1'b1;
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
    // Hold every output inactive for as long as reset is asserted.
    if (!resetBar) begin
      w_assert_rom = 1'b0;
      w_jump_bar   = 1'b1;
      w_load_a_bar = 1'b1;
      w_load_b_bar = 1'b1;
      w_halted     = 1'b0;
    end else begin
      w_halted     = w_halted;
    end
  end

  assign bus.assertRom = w_assert_rom;
  assign bus.doJumpBar = w_jump_bar;
  assign bus.loadABar  = w_load_a_bar;
  assign bus.loadBBar  = w_load_b_bar;
  assign bus.ir        = r_ir;
  assign bus.halted    = w_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench: models the 8-bit program counter, the ROM and registers A/B
//   around the sequencer, and checks outputs on the falling clock edge.
module tb_fetch_sequencer;

  logic       clk;
  logic       resetBar;
  logic       force_ff;
  logic [7:0] pc;
  logic [7:0] rom [256];
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  int         la_pulses;
  int         n_checks;
  int         n_fail;
  int         la_before;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dbus = force_ff ? 8'hFF : rom[pc];

  // Program counter model: load beats increment, reset clears asynchronously.
  always @(posedge clk or negedge resetBar) begin
    if (!resetBar) pc <= 8'h00;
    else if (!bus.doJumpBar) pc <= bus.dbus;
    else if (bus.assertRom) pc <= pc + 8'd1;
  end

  // Register file model and load-A pulse counter.
  always @(posedge clk) begin
    if (resetBar && !bus.loadABar) begin
      reg_a     <= bus.dbus;
      la_pulses <= la_pulses + 1;
    end
    if (resetBar && !bus.loadBBar) reg_b <= bus.dbus;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Pulse reset for one cycle; returns just after release, before the first edge.
  task automatic pulse_reset();
    @(negedge clk);
    resetBar = 1'b0;
    @(negedge clk);
    resetBar = 1'b1;
    #1;
  endtask

  // Conditional jump at 20 to 40; sel_c picks JC instead of JZ.
  task automatic run_cond(input logic sel_c, input logic taken);
    clear_rom();
    rom[8'h00] = 8'h82; rom[8'h01] = 8'h20;
    rom[8'h20] = sel_c ? 8'h84 : 8'h83; rom[8'h21] = 8'h40;
    rom[8'h22] = 8'h01; rom[8'h40] = 8'h01;
    bus.flagZ = sel_c ? ~taken : taken;
    bus.flagC = sel_c ? taken : ~taken;
    pulse_reset();
    @(negedge clk); @(negedge clk);
    check_val("cond_pc_at_20", {24'd0, pc}, 32'h20);
    @(negedge clk);
    check_val("cond_jump_bar", {31'd0, bus.doJumpBar}, {31'd0, ~taken});
    check_val("cond_assert_rom", {31'd0, bus.assertRom}, 32'd1);
    @(negedge clk);
    check_val("cond_next_pc", {24'd0, pc}, taken ? 32'h40 : 32'h22);
    @(negedge clk);
    check_val("cond_halted", {31'd0, bus.halted}, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; la_pulses = 0;
    reg_a = 8'h00; reg_b = 8'h00;
    resetBar = 1'b0; force_ff = 1'b1;
    bus.runEnable = 1'b1; bus.flagZ = 1'b0; bus.flagC = 1'b0;
    clear_rom();

    // Reset held three cycles with the ROM driving FF.
    repeat (3) @(negedge clk);
    check_val("rst_assert_rom", {31'd0, bus.assertRom}, 32'd0);
    check_val("rst_jump_bar", {31'd0, bus.doJumpBar}, 32'd1);
    check_val("rst_load_a_bar", {31'd0, bus.loadABar}, 32'd1);
    check_val("rst_load_b_bar", {31'd0, bus.loadBBar}, 32'd1);
    check_val("rst_halted", {31'd0, bus.halted}, 32'd0);
    check_val("rst_ir", {24'd0, bus.ir}, 32'h00);

    // LIA 5A, LIB C3, HALT.
    rom[8'h00] = 8'h80; rom[8'h01] = 8'h5A; rom[8'h02] = 8'h81;
    rom[8'h03] = 8'hC3; rom[8'h04] = 8'h01;
    force_ff = 1'b0;
    resetBar = 1'b1;
    #1;
    check_val("p1_first_pc", {24'd0, pc}, 32'h00);
    check_val("p1_first_fetch", {31'd0, bus.assertRom}, 32'd1);
    @(negedge clk);
    check_val("p1_lia_pc", {24'd0, pc}, 32'h01);
    check_val("p1_lia_strobe", {31'd0, bus.loadABar}, 32'd0);
    check_val("p1_lia_no_b", {31'd0, bus.loadBBar}, 32'd1);
    @(negedge clk);
    check_val("p1_lia_done", {31'd0, bus.loadABar}, 32'd1);
    check_val("p1_reg_a", {24'd0, reg_a}, 32'h5A);
    @(negedge clk);
    check_val("p1_lib_pc", {24'd0, pc}, 32'h03);
    check_val("p1_lib_strobe", {31'd0, bus.loadBBar}, 32'd0);
    @(negedge clk);
    check_val("p1_reg_b", {24'd0, reg_b}, 32'hC3);
    @(negedge clk);
    check_val("p1_halted", {31'd0, bus.halted}, 32'd1);
    check_val("p1_halt_pc", {24'd0, pc}, 32'h05);
    repeat (3) @(negedge clk);
    check_val("p1_pc_frozen", {24'd0, pc}, 32'h05);
    check_val("p1_halt_no_rom", {31'd0, bus.assertRom}, 32'd0);
    check_val("p1_ir_halt", {24'd0, bus.ir}, 32'h01);

    // JMP 10 then NOP, HALT.
    clear_rom();
    rom[8'h00] = 8'h82; rom[8'h01] = 8'h10; rom[8'h10] = 8'h00; rom[8'h11] = 8'h01;
    pulse_reset();
    check_val("p2_halt_cleared", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    check_val("p2_jmp_strobe", {31'd0, bus.doJumpBar}, 32'd0);
    @(negedge clk);
    check_val("p2_pc_10", {24'd0, pc}, 32'h10);
    check_val("p2_no_jump", {31'd0, bus.doJumpBar}, 32'd1);
    @(negedge clk);
    check_val("p2_pc_11", {24'd0, pc}, 32'h11);
    @(negedge clk);
    check_val("p2_halted", {31'd0, bus.halted}, 32'd1);
    check_val("p2_pc_12", {24'd0, pc}, 32'h12);

    // Conditional jumps, both flags, both outcomes.
    run_cond(1'b0, 1'b0);
    run_cond(1'b0, 1'b1);
    run_cond(1'b1, 1'b0);
    run_cond(1'b1, 1'b1);
    bus.flagZ = 1'b0; bus.flagC = 1'b0;

    // Stall during the IMM cycle of LIA A7.
    clear_rom();
    rom[8'h00] = 8'h80; rom[8'h01] = 8'hA7; rom[8'h02] = 8'h01;
    pulse_reset();
    @(negedge clk);
    bus.runEnable = 1'b0;
    la_before = la_pulses;
    #1;
    check_val("stall_assert_rom", {31'd0, bus.assertRom}, 32'd0);
    check_val("stall_load_a_bar", {31'd0, bus.loadABar}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("stall_pc_hold", {24'd0, pc}, 32'h01);
      check_val("stall_ir_hold", {24'd0, bus.ir}, 32'h80);
      check_val("stall_no_strobe", {31'd0, bus.loadABar}, 32'd1);
    end
    bus.runEnable = 1'b1;
    #1;
    check_val("resume_strobe", {31'd0, bus.loadABar}, 32'd0);
    @(negedge clk);
    check_val("resume_pc", {24'd0, pc}, 32'h02);
    check_val("resume_reg_a", {24'd0, reg_a}, 32'hA7);
    check_val("resume_one_pulse", la_pulses - la_before, 32'd1);

    // Asynchronous reset during the IMM cycle of JMP 30.
    clear_rom();
    rom[8'h00] = 8'h82; rom[8'h01] = 8'h30;
    pulse_reset();
    @(negedge clk);
    check_val("arst_jmp_before", {31'd0, bus.doJumpBar}, 32'd0);
    #1;
    resetBar = 1'b0;
    #1;
    check_val("arst_jump_bar", {31'd0, bus.doJumpBar}, 32'd1);
    check_val("arst_assert_rom", {31'd0, bus.assertRom}, 32'd0);
    @(negedge clk);
    check_val("arst_no_load", {24'd0, pc}, 32'h00);
    resetBar = 1'b1;
    #1;
    check_val("arst_refetch", {31'd0, bus.assertRom}, 32'd1);
    check_val("arst_ir_clear", {24'd0, bus.ir}, 32'h00);
    @(negedge clk);
    check_val("arst_pc_1", {24'd0, pc}, 32'h01);
    @(negedge clk);
    check_val("arst_pc_30", {24'd0, pc}, 32'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control-side partner of the 8-bit program counter. It drives the counter's `assertRom` (count) and `doJumpBar` (load) inputs.
- It consumes the ROM byte the counter's address selects, which appears on the shared `dbus`.
- Runs a small fetch/immediate/halt FSM, latches the opcode, and issues register-load strobes and jumps.
- Sits between the ROM/program counter and the register file/ALU flags.

Parameters:
- DATA_W, 8, width of `dbus` and instruction register; fixed at 8, since the counter is 2×4-bit.
- HALT_OP, 8'h01, opcode that stops fetch.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- resetBar  in  1  asynchronous active-low reset
- dbus  in  8  ROM byte for the current pc; valid while assertRom=1
- flagZ  in  1  zero flag from ALU, sampled in the IMM cycle
- flagC  in  1  carry flag from ALU, sampled in the IMM cycle
- runEnable  in  1  1=advance; 0=stall, with state and pc frozen
- assertRom  out  1  ROM drives dbus and pc increments at the next edge
- doJumpBar  out  1  active-low; pc loads dbus at the next edge
- loadABar  out  1  active-low; reg A captures dbus at the next edge
- loadBBar  out  1  active-low; reg B captures dbus at the next edge
- ir  out  8  last fetched opcode
- halted  out  1  FSM is in HALT

Behaviour:
- Reset (resetBar low, asynchronous):
  - state=FETCH, ir=8'h00.
  - All outputs inactive: assertRom=0, doJumpBar=1, loadABar=1, loadBBar=1, halted=0.
  - Outputs are gated by resetBar, so they stay inactive while reset is held.
  - Reset mid-instruction abandons it; an immediate is never consumed after reset.
- Opcode encoding:
  - Bit7=1 means a one-byte immediate follows.
  - 8'h00 NOP. HALT_OP halts.
  - 8'h80 LIA, 8'h81 LIB, 8'h82 JMP, 8'h83 JZ, 8'h84 JC.
  - Any other bit7=0 opcode is a NOP.
  - Any other bit7=1 opcode consumes its immediate with no effect.
- FETCH (runEnable=1):
  - assertRom=1.
  - At the edge: ir<=dbus and pc increments.
  - Next state: IMM if dbus[7]; HALT if dbus==HALT_OP; else FETCH.
- IMM (runEnable=1):
  - assertRom=1; dbus holds the immediate.
  - Decode of ir is combinational in this cycle:
    - LIA: loadABar=0.
    - LIB: loadBBar=0.
    - JMP: doJumpBar=0.
    - JZ: doJumpBar=!flagZ, i.e. low when flagZ=1.
    - JC: doJumpBar=!flagC, i.e. low when flagC=1.
  - A taken jump loads the immediate, overriding the increment; otherwise pc increments past the immediate.
  - Next state: FETCH.
- HALT:
  - All strobes inactive, assertRom=0, halted=1; pc frozen.
  - Leaves HALT only via reset.
- runEnable=0 in any state:
  - assertRom=0, all strobes inactive, state and ir hold.
  - Resuming continues the same cycle type.
- Timing:
  - Strobes are combinational from state, ir, flags and runEnable; glitch-free with respect to state because ir and state are registered.
  - Never assert doJumpBar=0 when assertRom=0.
- Boundary behaviour:
  - pc wrap 8'hFF->8'h00 is the counter's concern; the sequencer is unaffected.
  - An immediate opcode at 8'hFF takes its immediate from 8'h00.
  - A jump target equal to the current pc is legal (tight loop).
- CPI: one-byte instructions take 1 cycle; two-byte instructions take 2 cycles.

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP, OP_HALT, OP_LIA, OP_LIB, OP_JMP, OP_JZ, OP_JC);
  - state encoding (FETCH=2'd0, IMM=2'd1, HALT=2'd2);
  - the IMM_BIT index (7).
- One natural sub-module, `fetch_decode`: combinational map from (ir, flagZ, flagC) to {loadA, loadB, jump}.
- The FSM and ir register stay in the top level.

Test Plan:
- Reset held 3 cycles with the ROM driving 8'hFF → assertRom=0, doJumpBar=1, halted=0, ir=00. Release → first FETCH at pc=00.
- ROM {00:80, 01:5A, 02:81, 03:C3, 04:01} → loadABar low exactly in the pc=01 cycle (A=5A), loadBBar low at pc=03 (B=C3), then halted=1 with pc frozen at 05.
- ROM {00:82, 01:10, 10:00, 11:01} → doJumpBar low in the pc=01 cycle, next pc=10, then 11, then halt with pc=12.
- JZ at 20 with target 40: flagZ=0 → pc proceeds 22; flagZ=1 → pc=40. Repeat with JC and flagC.
- runEnable dropped during the IMM cycle of an LIA for 4 cycles → no strobes, pc and ir hold; on re-enable, loadABar pulses once and the correct byte loads.
- Async reset asserted mid-IMM of a JMP → doJumpBar returns to 1 immediately, no load occurs, and fetch restarts at pc=00.
